// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: one saturating pending-write counter per architectural
// register, combinational stall for RAW / counter-capacity hazards, flush and sticky underflow.
module hazard_scoreboard #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_ra_used,
    input  logic [3:0]       issue_ra,
    input  logic             issue_rb_used,
    input  logic [3:0]       issue_rb,
    input  logic             issue_writes,
    input  logic [3:0]       issue_rt,
    input  logic             retire_valid,
    input  logic             retire_writes,
    input  logic [3:0]       retire_rt,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic [15:0]      busy_mask,
    output logic [CNT_W+3:0] inflight,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt      [16];
    logic [CNT_W-1:0] cnt_next [16];
    logic [15:0]      busy_next;
    logic [CNT_W+3:0] inflight_next;
    logic             src_hazard;
    logic             cap_hazard;
    logic             inc_en;
    logic             dec_en;
    logic             uf_hit;

    // Hazards look only at registered counters; a same-cycle retire never unblocks a reader.
    always_comb begin
        src_hazard = (issue_ra_used && (issue_ra != 4'd0) && (cnt[issue_ra] != '0)) ||
                     (issue_rb_used && (issue_rb != 4'd0) && (cnt[issue_rb] != '0));
        cap_hazard = issue_writes && (issue_rt != 4'd0) && (cnt[issue_rt] == MAX);
        stall      = issue_valid && !flush && !reset && (src_hazard || cap_hazard);
        issue_fire = issue_valid && !stall && !flush;
    end

    always_comb begin
        inc_en = issue_fire && issue_writes && (issue_rt != 4'd0);
        dec_en = retire_valid && retire_writes && (retire_rt != 4'd0) &&
                 (cnt[retire_rt] != '0);
        uf_hit = retire_valid && retire_writes && (retire_rt != 4'd0) &&
                 (cnt[retire_rt] == '0) && !flush;
    end

    // Next counter state; r0 is never tracked, and a flush discards same-cycle issue/retire.
    always_comb begin
        inflight_next = '0;
        busy_next     = '0;
        for (int r = 0; r < 16; r++) begin
            cnt_next[r] = cnt[r];
            if (r == 0 || flush) begin
                cnt_next[r] = '0;
            end else begin
                if (inc_en && (issue_rt == 4'(r))) begin
                    cnt_next[r] = cnt_next[r] + CNT_W'(1);
                end
                if (dec_en && (retire_rt == 4'(r))) begin
                    cnt_next[r] = cnt_next[r] - CNT_W'(1);
                end
            end
            busy_next[r]  = (cnt_next[r] != '0);
            inflight_next = inflight_next + (CNT_W+4)'(cnt_next[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 16; r++) begin
                cnt[r] <= '0;
            end
            busy_mask     <= '0;
            inflight      <= '0;
            underflow_err <= 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                cnt[r] <= cnt_next[r];
            end
            busy_mask <= busy_next;
            inflight  <= inflight_next;
            if (uf_hit) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-register pending-write model checked every
// cycle, plus hand-computed literal expectations for the named scenarios.
module tb_hazard_scoreboard;

    localparam int CNT_W = 3;
    localparam int MAXV  = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid, issue_ra_used, issue_rb_used, issue_writes;
    logic [3:0]       issue_ra, issue_rb, issue_rt;
    logic             retire_valid, retire_writes;
    logic [3:0]       retire_rt;
    logic             flush;
    logic             stall, issue_fire, underflow_err;
    logic [15:0]      busy_mask;
    logic [CNT_W+3:0] inflight;

    int  vectors    = 0;
    int  miscompares = 0;
    bit  en         = 1'b0;
    int  mcnt [16];
    bit  muf        = 1'b0;

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ra_used(issue_ra_used), .issue_ra(issue_ra),
        .issue_rb_used(issue_rb_used), .issue_rb(issue_rb),
        .issue_writes(issue_writes), .issue_rt(issue_rt),
        .retire_valid(retire_valid), .retire_writes(retire_writes), .retire_rt(retire_rt),
        .flush(flush), .stall(stall), .issue_fire(issue_fire),
        .busy_mask(busy_mask), .inflight(inflight), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reg_pending(input logic [3:0] r);
        return (r != 4'd0) && (mcnt[r] != 0);
    endfunction

    function automatic bit model_stall();
        bit hz;
        hz = (issue_ra_used && reg_pending(issue_ra)) ||
             (issue_rb_used && reg_pending(issue_rb)) ||
             (issue_writes && issue_rt != 4'd0 && mcnt[issue_rt] == MAXV);
        return issue_valid && !flush && !reset && hz;
    endfunction

    // Model: counts outstanding writes per register; updated on each active edge.
    always @(posedge clk) begin
        bit fire;
        fire = issue_valid && !model_stall() && !flush;
        if (reset) begin
            foreach (mcnt[r]) mcnt[r] = 0;
            muf = 1'b0;
        end else if (flush) begin
            foreach (mcnt[r]) mcnt[r] = 0;
        end else begin
            int pre_ret;
            pre_ret = mcnt[retire_rt];
            if (fire && issue_writes && issue_rt != 4'd0) mcnt[issue_rt] = mcnt[issue_rt] + 1;
            if (retire_valid && retire_writes && retire_rt != 4'd0) begin
                if (pre_ret == 0) muf = 1'b1;
                else mcnt[retire_rt] = mcnt[retire_rt] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            bit          s;
            logic [15:0] m;
            int          sum;
            s   = model_stall();
            m   = '0;
            sum = 0;
            for (int r = 1; r < 16; r++) begin
                m[r] = (mcnt[r] != 0);
                sum += mcnt[r];
            end
            check("stall",         32'(stall),         32'(s));
            check("issue_fire",    32'(issue_fire),    32'(issue_valid && !s && !flush));
            check("busy_mask",     32'(busy_mask),     32'(m));
            check("inflight",      32'(inflight),      32'(sum));
            check("underflow_err", 32'(underflow_err), 32'(muf));
        end
    end

    task automatic idle();
        issue_valid = 0; issue_ra_used = 0; issue_rb_used = 0; issue_writes = 0;
        issue_ra = 0; issue_rb = 0; issue_rt = 0;
        retire_valid = 0; retire_writes = 0; retire_rt = 0;
        flush = 0; reset = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_w(input logic [3:0] rt);
        idle();
        issue_valid = 1; issue_writes = 1; issue_rt = rt;
    endtask

    task automatic retire_w(input logic [3:0] rt);
        idle();
        retire_valid = 1; retire_writes = 1; retire_rt = rt;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        en = 1'b1;
        idle();
        @(negedge clk);
        check("reset_inflight", 32'(inflight), 32'd0);
        check("reset_busy",     32'(busy_mask), 32'd0);
        tick();

        // RAW: writer to r3, then dependent reader held until r3 retires
        issue_w(4'd3);
        tick();
        idle(); issue_valid = 1; issue_ra_used = 1; issue_ra = 4'd3;
        @(negedge clk);
        check("raw_stall_n1", 32'(stall), 32'd1);
        check("raw_busy",     32'(busy_mask), 32'h0008);
        tick();
        tick();
        retire_valid = 1; retire_writes = 1; retire_rt = 4'd3;
        @(negedge clk);
        check("raw_no_bypass", 32'(stall), 32'd1);
        tick();
        retire_valid = 0; retire_writes = 0; retire_rt = 0;
        @(negedge clk);
        check("raw_release",    32'(stall), 32'd0);
        check("raw_busy_clear", 32'(busy_mask), 32'h0000);
        tick();

        // r0 is never tracked
        issue_w(4'd0);
        tick();
        idle(); issue_valid = 1; issue_ra_used = 1; issue_rb_used = 1;
        @(negedge clk);
        check("r0_stall", 32'(stall), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("r0_inflight", 32'(inflight), 32'd0);
        check("r0_busy",     32'(busy_mask), 32'h0000);
        tick();

        // Saturation: seven writes to r5 fill the counter, the eighth stalls
        for (int i = 0; i < 7; i++) begin
            issue_w(4'd5);
            tick();
        end
        idle();
        @(negedge clk);
        check("sat_inflight", 32'(inflight), 32'd7);
        check("sat_busy",     32'(busy_mask), 32'h0020);
        tick();
        issue_w(4'd5);
        @(negedge clk);
        check("sat_stall", 32'(stall), 32'd1);
        check("sat_fire",  32'(issue_fire), 32'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            retire_w(4'd5);
            tick();
        end
        idle();
        @(negedge clk);
        check("sat_drained", 32'(inflight), 32'd0);
        tick();

        // Simultaneous issue and retire to r4 with cnt[4]=2
        issue_w(4'd4); tick();
        issue_w(4'd4); tick();
        idle();
        @(negedge clk);
        check("sim_before", 32'(inflight), 32'd2);
        tick();
        issue_w(4'd4);
        retire_valid = 1; retire_writes = 1; retire_rt = 4'd4;
        tick();
        idle();
        @(negedge clk);
        check("sim_inflight", 32'(inflight), 32'd2);
        check("sim_busy",     32'(busy_mask), 32'h0010);
        tick();
        retire_w(4'd4); tick();
        retire_w(4'd4); tick();

        // Ignored fields: no valid issue, retire without a write
        idle(); issue_writes = 1; issue_rt = 4'd8;
        tick();
        idle(); retire_valid = 1; retire_rt = 4'd2;
        tick();

        // Flush with cnt[2]=1, cnt[7]=3 and a concurrent issue to r9
        issue_w(4'd2); tick();
        for (int i = 0; i < 3; i++) begin
            issue_w(4'd7); tick();
        end
        issue_w(4'd9); flush = 1;
        @(negedge clk);
        check("flush_fire",  32'(issue_fire), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("flush_busy",     32'(busy_mask), 32'h0000);
        check("flush_inflight", 32'(inflight), 32'd0);
        tick();

        // Underflow is sticky across flush and cleared only by reset
        retire_w(4'd6);
        tick();
        idle();
        @(negedge clk);
        check("uf_set", 32'(underflow_err), 32'd1);
        tick();
        issue_w(4'd1); tick();
        idle(); flush = 1; tick();
        idle();
        @(negedge clk);
        check("uf_after_flush", 32'(underflow_err), 32'd1);
        tick();
        idle(); reset = 1; tick();
        idle();
        @(negedge clk);
        check("uf_reset", 32'(underflow_err), 32'd0);
        tick();

        // Mixed traffic over a small register set, model-checked each cycle
        for (int i = 0; i < 300; i++) begin
            idle();
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_ra_used = $urandom_range(0, 1);
            issue_rb_used = $urandom_range(0, 1);
            issue_writes  = ($urandom_range(0, 3) != 0);
            issue_ra      = 4'($urandom_range(0, 5));
            issue_rb      = 4'($urandom_range(0, 5));
            issue_rt      = 4'($urandom_range(0, 5));
            retire_valid  = $urandom_range(0, 1);
            retire_writes = ($urandom_range(0, 3) != 0);
            retire_rt     = 4'($urandom_range(0, 5));
            flush         = ($urandom_range(0, 40) == 0);
            reset         = ($urandom_range(0, 80) == 0);
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
